// File: rtl/mux16b16_pkg.sv
// Shared width and select encodings for the 16-way registered selector.
package mux16b16_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] SEL_A = 4'h0;
  localparam logic [3:0] SEL_B = 4'h1;
  localparam logic [3:0] SEL_C = 4'h2;
  localparam logic [3:0] SEL_D = 4'h3;
  localparam logic [3:0] SEL_E = 4'h4;
  localparam logic [3:0] SEL_F = 4'h5;
  localparam logic [3:0] SEL_G = 4'h6;
  localparam logic [3:0] SEL_H = 4'h7;
  localparam logic [3:0] SEL_I = 4'h8;
  localparam logic [3:0] SEL_J = 4'h9;
  localparam logic [3:0] SEL_K = 4'hA;
  localparam logic [3:0] SEL_L = 4'hB;
  localparam logic [3:0] SEL_M = 4'hC;
  localparam logic [3:0] SEL_N = 4'hD;
  localparam logic [3:0] SEL_O = 4'hE;
  localparam logic [3:0] SEL_P = 4'hF;

endpackage

// File: rtl/mux16b16_mux4_w.sv
// Combinational W-bit 4:1 selector used as a building block of the 16:1 tree.
module mux4_w #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = a;
    unique case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
    endcase
  end

endmodule

// File: rtl/mux16b16.sv
// 16-way, 16-bit selector: two-level 4:1 mux tree feeding a single output register.
module mux16b16
  import mux16b16_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] O,
  input  logic [WIDTH-1:0] P,
  input  logic [3:0]       S,
  output logic [WIDTH-1:0] Result
);

  logic [WIDTH-1:0] grp_ad;
  logic [WIDTH-1:0] grp_eh;
  logic [WIDTH-1:0] grp_il;
  logic [WIDTH-1:0] grp_mp;
  logic [WIDTH-1:0] sel_out;

  // Low select bits pick within each group of four, high bits pick the group.
  mux4_w #(.W(WIDTH)) u_mux_ad (.a(A), .b(B), .c(C), .d(D), .sel(S[1:0]), .y(grp_ad));
  mux4_w #(.W(WIDTH)) u_mux_eh (.a(E), .b(F), .c(G), .d(H), .sel(S[1:0]), .y(grp_eh));
  mux4_w #(.W(WIDTH)) u_mux_il (.a(I), .b(J), .c(K), .d(L), .sel(S[1:0]), .y(grp_il));
  mux4_w #(.W(WIDTH)) u_mux_mp (.a(M), .b(N), .c(O), .d(P), .sel(S[1:0]), .y(grp_mp));

  mux4_w #(.W(WIDTH)) u_mux_top (
    .a  (grp_ad),
    .b  (grp_eh),
    .c  (grp_il),
    .d  (grp_mp),
    .sel(S[3:2]),
    .y  (sel_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) Result <= '0;
    else     Result <= sel_out;
  end

endmodule

// File: tb/tb_mux16b16.sv
// Directed self-checking bench for the registered 16-way selector.
module tb_mux16b16;

  logic        CLK;
  logic        RST;
  logic [15:0] din [16];
  logic [3:0]  S;
  logic [15:0] Result;

  int checks;
  int errors;

  mux16b16 dut (
    .CLK(CLK), .RST(RST),
    .A(din[0]),  .B(din[1]),  .C(din[2]),  .D(din[3]),
    .E(din[4]),  .F(din[5]),  .G(din[6]),  .H(din[7]),
    .I(din[8]),  .J(din[9]),  .K(din[10]), .L(din[11]),
    .M(din[12]), .N(din[13]), .O(din[14]), .P(din[15]),
    .S(S), .Result(Result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (Result === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, Result, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with every input non-zero
    for (int i = 0; i < 16; i++)
      din[i] = (i == 15) ? 16'hFFFF : 16'(16'h1111 * (i + 1));
    S   = 4'h7;
    RST = 1'b1;
    tick();
    chk("reset_edge1", 16'h0000);
    tick();
    chk("reset_edge2", 16'h0000);

    // Full sweep of every select code
    for (int i = 0; i < 16; i++) din[i] = 16'hA000 + 16'(i);
    RST = 1'b0;
    for (int s = 0; s < 16; s++) begin
      S = 4'(s);
      tick();
      chk($sformatf("sweep_s%0d", s), 16'hA000 + 16'(s));
    end

    // Latency: mid-cycle select change must not show until next edge
    din[0]  = 16'h1234;
    din[15] = 16'hBEEF;
    S = 4'h0;
    tick();
    chk("lat_a", 16'h1234);
    #3;
    S = 4'hF;
    #2;
    chk("lat_hold", 16'h1234);
    tick();
    chk("lat_p", 16'hBEEF);

    // Data-only change with select held
    S = 4'hC;
    din[12] = 16'h0001;
    tick();
    chk("data_m1", 16'h0001);
    din[12] = 16'h8000;
    #3;
    chk("data_hold", 16'h0001);
    tick();
    chk("data_m2", 16'h8000);

    // Simultaneous select and data change
    S = 4'h9;
    din[9] = 16'h0F0F;
    tick();
    chk("simul_j", 16'h0F0F);

    // Reset mid-operation, then resume
    S = 4'h5;
    din[5] = 16'h5A5A;
    tick();
    chk("pre_rst_f", 16'h5A5A);
    RST = 1'b1;
    tick();
    chk("mid_rst", 16'h0000);
    RST = 1'b0;
    tick();
    chk("post_rst_f", 16'h5A5A);

    // Unknown select during reset still yields zero
    RST = 1'b1;
    S = 4'bxxxx;
    tick();
    chk("rst_xsel", 16'h0000);
    RST = 1'b0;

    // Isolation: only D may reach the output
    S = 4'h3;
    din[3] = 16'h3C3C;
    tick();
    chk("iso_base", 16'h3C3C);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++)
        if (i != 3) din[i] = din[i] ^ 16'hFFFF ^ 16'(t * 16'h0101);
      tick();
      chk($sformatf("iso_t%0d", t), 16'h3C3C);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
